// File: rtl/fu_wb_if.sv
// Writeback bus between the functional-unit completion ports and the register-file write port.
// master = FU side / environment, slave = writeback arbiter.
interface fu_wb_if #(
  parameter int NUM_FU = 5
);
  logic [NUM_FU-1:0]    fu_finish;
  logic [32*NUM_FU-1:0] fu_res;
  logic [5*NUM_FU-1:0]  fu_rd;
  logic                 wb_en;
  logic [4:0]           wb_rd;
  logic [31:0]          wb_data;
  logic [2:0]           wb_fu;
  logic [NUM_FU-1:0]    fu_pending;
  logic                 overflow;

  modport master (
    output fu_finish, fu_res, fu_rd,
    input  wb_en, wb_rd, wb_data, wb_fu, fu_pending, overflow
  );

  modport slave (
    input  fu_finish, fu_res, fu_rd,
    output wb_en, wb_rd, wb_data, wb_fu, fu_pending, overflow
  );
endinterface

// File: rtl/fu_wb_arbiter.sv
// Writeback arbiter: captures one-cycle FU completions into per-FU holding slots and
// drives a single register-file write per cycle (fixed priority or round-robin).

module fu_wb_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        fin_i,
  input  logic        gnt_i,
  input  logic [31:0] res_i,
  input  logic [4:0]  rd_i,
  output logic        vld_o,
  output logic [31:0] data_o,
  output logic [4:0]  rd_o,
  output logic        ovf_o
);
  logic        vld_q, vld_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  rd_q, rd_d;
  logic        take, load;

  // A write to r0 is architecturally a no-op, so it never occupies the slot.
  // A slot being drained this cycle can accept a new result on the same edge.
  always_comb begin
    take   = fin_i && (rd_i != 5'd0);
    load   = take && (!vld_q || gnt_i);
    vld_d  = load || (vld_q && !gnt_i);
    data_d = load ? res_i : data_q;
    rd_d   = load ? rd_i  : rd_q;
    ovf_o  = take && vld_q && !gnt_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      rd_q   <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      rd_q   <= rd_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign rd_o   = rd_q;
endmodule

module fu_wb_arbiter #(
  parameter int NUM_FU = 5,
  parameter bit RR_EN  = 1'b0
) (
  input  logic   clk,
  input  logic   rst,
  fu_wb_if.slave bus
);
  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0]           slot_vld;
  logic [NUM_FU-1:0]           slot_ovf;
  logic [NUM_FU-1:0]           gnt_oh;
  logic [NUM_FU-1:0][31:0]     slot_data;
  logic [NUM_FU-1:0][4:0]      slot_rd;

  logic [IDX_W-1:0]            ptr_q, ptr_d;
  logic                        ovf_q, ovf_d;
  logic [IDX_W-1:0]            base;
  logic [IDX_W-1:0]            gnt_idx;
  logic                        gnt_any;
  int                          scan;

  genvar g;
  generate
    for (g = 0; g < NUM_FU; g++) begin : g_slot
      fu_wb_slot u_slot (
        .clk    (clk),
        .rst    (rst),
        .fin_i  (bus.fu_finish[g]),
        .gnt_i  (gnt_oh[g]),
        .res_i  (bus.fu_res[32*g +: 32]),
        .rd_i   (bus.fu_rd[5*g +: 5]),
        .vld_o  (slot_vld[g]),
        .data_o (slot_data[g]),
        .rd_o   (slot_rd[g]),
        .ovf_o  (slot_ovf[g])
      );
    end
  endgenerate

  // Search starts at the pointer in round-robin mode and at 0 in fixed mode,
  // wrapping so every slot is visited once.
  always_comb begin
    base    = RR_EN ? ptr_q : '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    scan    = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan = int'(base) + k;
      if (scan >= NUM_FU) scan = scan - NUM_FU;
      if (!gnt_any && slot_vld[IDX_W'(scan)]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(scan);
      end
    end
    if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (RR_EN && gnt_any)
      ptr_d = (gnt_idx == IDX_W'(NUM_FU - 1)) ? '0 : gnt_idx + 1'b1;
    ovf_d = ovf_q || (|slot_ovf);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.wb_en      = gnt_any;
  assign bus.wb_rd      = gnt_any ? slot_rd[gnt_idx]   : 5'd0;
  assign bus.wb_data    = gnt_any ? slot_data[gnt_idx] : 32'd0;
  assign bus.wb_fu      = gnt_any ? 3'(gnt_idx)        : 3'd0;
  assign bus.fu_pending = slot_vld;
  assign bus.overflow   = ovf_q;
endmodule
